// File: rtl/fir_pkg.sv
// Shared sizes and state encoding for the FIR tap sequencer.
package fir_pkg;
  localparam int DEF_TAPS    = 10;
  localparam int DEF_COEFF_W = 16;
  localparam int DEF_DATA_W  = 3;
  localparam int DEF_ADDR_W  = 4;
  localparam int INSEL_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line: shifts on enable, read by tap index.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int DEPTH = DEF_TAPS,
  parameter int W     = DEF_DATA_W,
  parameter int IDX_W = DEF_ADDR_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_shift,
  input  logic [W-1:0]     i_din,
  input  logic [IDX_W-1:0] i_idx,
  output logic [W-1:0]     o_dout
);

  logic [W-1:0] r_dly [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_dly[k] <= '0;
      end
    end else if (i_shift) begin
      r_dly[0] <= i_din;
      for (int k = 1; k < DEPTH; k++) begin
        r_dly[k] <= r_dly[k-1];
      end
    end
  end

  assign o_dout = r_dly[i_idx];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Walks the coefficient SRAM once per accepted sample and feeds
// aligned (coefficient, delayed sample) pairs to the MAC.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS    = DEF_TAPS,
  parameter int COEFF_W = DEF_COEFF_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               iClk_12M,
  input  logic               iRst,
  input  logic               iEnSample,
  input  logic [DATA_W-1:0]  iFirIn,
  input  logic               iUpdate,
  input  logic [COEFF_W-1:0] iRdDt,
  output logic               oCsn,
  output logic [ADDR_W-1:0]  oAddr,
  output logic [COEFF_W-1:0] oCoeff,
  output logic [DATA_W-1:0]  oFirIn,
  output logic [3:0]         oInSel,
  output logic               oEnDelay,
  output logic               oBusy,
  output logic               oOverrun
);

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0]  r_tap;
  logic [ADDR_W-1:0]  w_tap_nxt;
  logic               r_drn;
  logic               w_drn_nxt;
  logic               w_accept;
  logic               w_last;

  logic               r_v1;
  logic [ADDR_W-1:0]  r_t1;
  logic [DATA_W-1:0]  w_dly_out;

  logic               r_csn;
  logic [COEFF_W-1:0] r_coeff;
  logic [DATA_W-1:0]  r_fir;
  logic [3:0]         r_insel;
  logic               r_endly;
  logic               r_busy;
  logic               r_ovr;

  assign w_last = (r_tap == ADDR_W'(TAPS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_tap_nxt   = r_tap;
    w_drn_nxt   = r_drn;
    w_accept    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (iEnSample && !iUpdate) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
          w_tap_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DRAIN;
          w_drn_nxt   = 1'b0;
        end else begin
          w_tap_nxt = r_tap + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        w_drn_nxt = 1'b1;
        if (r_drn) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      r_state <= ST_IDLE;
      r_tap   <= '0;
      r_drn   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tap   <= w_tap_nxt;
      r_drn   <= w_drn_nxt;
    end
  end

  // Read data arrives one cycle after the address, so the tap index
  // is carried one stage to line the sample up with its coefficient.
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      r_csn   <= 1'b1;
      r_v1    <= 1'b0;
      r_t1    <= '0;
      r_coeff <= '0;
      r_fir   <= '0;
      r_insel <= '0;
      r_endly <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_csn  <= (w_state_nxt != ST_RUN);
      r_busy <= (w_state_nxt != ST_IDLE);
      r_v1   <= ~r_csn;
      r_t1   <= r_tap;
      if (r_v1) begin
        r_coeff <= iRdDt;
        r_fir   <= w_dly_out;
        r_insel <= INSEL_W'(r_t1) + 4'd1;
        r_endly <= (r_t1 == ADDR_W'(TAPS - 1));
      end else begin
        r_insel <= '0;
        r_endly <= 1'b0;
      end
      if (iEnSample && r_busy) begin
        r_ovr <= 1'b1;
      end
    end
  end

  fir_delay_line #(
    .DEPTH (TAPS),
    .W     (DATA_W),
    .IDX_W (ADDR_W)
  ) u_dly (
    .i_clk   (iClk_12M),
    .i_rst   (iRst),
    .i_shift (w_accept),
    .i_din   (iFirIn),
    .i_idx   (r_t1),
    .o_dout  (w_dly_out)
  );

  assign oCsn     = r_csn;
  assign oAddr    = r_tap;
  assign oCoeff   = r_coeff;
  assign oFirIn   = r_fir;
  assign oInSel   = r_insel;
  assign oEnDelay = r_endly;
  assign oBusy    = r_busy;
  assign oOverrun = r_ovr;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a registered SRAM model.
module tb_fir_tap_sequencer;
  import fir_pkg::*;

  localparam int TAPS    = 10;
  localparam int COEFF_W = 16;
  localparam int DATA_W  = 3;
  localparam int ADDR_W  = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en  = 1'b0;
  logic               upd = 1'b0;
  logic [DATA_W-1:0]  din = '0;
  logic [COEFF_W-1:0] rd_dt = '0;

  logic               o_csn;
  logic [ADDR_W-1:0]  o_addr;
  logic [COEFF_W-1:0] o_coeff;
  logic [DATA_W-1:0]  o_fir;
  logic [3:0]         o_insel;
  logic               o_endly;
  logic               o_busy;
  logic               o_ovr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rd_dt <= 16'h0100 + 16'(o_addr);

  fir_tap_sequencer #(
    .TAPS    (TAPS),
    .COEFF_W (COEFF_W),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .iClk_12M  (clk),
    .iRst      (rst),
    .iEnSample (en),
    .iFirIn    (din),
    .iUpdate   (upd),
    .iRdDt     (rd_dt),
    .oCsn      (o_csn),
    .oAddr     (o_addr),
    .oCoeff    (o_coeff),
    .oFirIn    (o_fir),
    .oInSel    (o_insel),
    .oEnDelay  (o_endly),
    .oBusy     (o_busy),
    .oOverrun  (o_ovr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    upd = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [DATA_W-1:0] d);
    din = d;
    en  = 1'b1;
    step();
    en  = 1'b0;
  endtask

  task automatic test_reset();
    logic [30:0] g;
    rst = 1'b1;
    en  = 1'b1;
    din = 3'b101;
    step();
    g = {o_csn, o_addr, o_coeff, o_fir, o_insel, o_endly, o_busy, o_ovr};
    n_tests++;
    if (g !== {1'b1, 30'b0}) begin
      n_fail++;
      $display("FAIL reset_vals got=%h exp=%h", g, {1'b1, 30'b0});
    end
    rst = 1'b0;
    en  = 1'b0;
    step();
    n_tests++;
    if ({o_csn, o_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_priority csn,busy got=%b exp=10", {o_csn, o_busy});
    end
  endtask

  task automatic test_run();
    logic [DATA_W-1:0]  smp [2];
    logic [DATA_W-1:0]  ef;
    logic [DATA_W-1:0]  lf;
    logic [COEFF_W-1:0] lc;
    logic [3:0]         ei;
    logic [25:0]        g;
    logic [25:0]        e;
    int t;
    smp[0] = 3'b001;
    smp[1] = 3'b111;
    lf = '0;
    lc = '0;
    do_reset();
    pulse(smp[0]);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k <= TAPS + 2; k++) begin
        ei = 4'd0;
        if (k >= 2 && k <= TAPS + 1) begin
          t  = k - 2;
          ef = (t == 0) ? smp[r] : ((t == 1 && r == 1) ? smp[0] : 3'b000);
          lf = ef;
          lc = 16'h0100 + 16'(t);
          ei = 4'(t + 1);
        end
        e = {(k >= TAPS), ei, (k == TAPS + 1), (k <= TAPS + 1), lf, lc};
        g = {o_csn, o_insel, o_endly, o_busy, o_fir, o_coeff};
        n_tests++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL run%0d_c%0d csn,insel,endly,busy,fir,coeff got=%h exp=%h",
                   r, k, g, e);
        end
        if (k < TAPS) begin
          n_tests++;
          if (o_addr !== 4'(k)) begin
            n_fail++;
            $display("FAIL run%0d_addr_c%0d got=%0d exp=%0d", r, k, o_addr, k);
          end
        end
        if (k == TAPS + 2 && r == 0) begin
          din = smp[1];
          en  = 1'b1;
        end
        step();
        en = 1'b0;
      end
    end
    n_tests++;
    if (o_ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL run_no_overrun got=%b exp=0", o_ovr);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    pulse(3'b011);
    repeat (5) step();
    pulse(3'b101);
    n_tests++;
    if ({o_ovr, o_busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL ovr_set ovr,busy got=%b exp=11", {o_ovr, o_busy});
    end
    repeat (6) step();
    n_tests++;
    if ({o_ovr, o_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL ovr_sticky ovr,busy got=%b exp=10", {o_ovr, o_busy});
    end
    pulse(3'b010);
    n_tests++;
    if ({o_csn, o_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL ovr_next_accept csn,busy got=%b exp=01", {o_csn, o_busy});
    end
    step();
    step();
    n_tests++;
    if (o_fir !== 3'b010) begin
      n_fail++;
      $display("FAIL ovr_tap1 got=%b exp=010", o_fir);
    end
    step();
    n_tests++;
    if (o_fir !== 3'b011) begin
      n_fail++;
      $display("FAIL ovr_tap2_no_shift got=%b exp=011", o_fir);
    end
    step();
    n_tests++;
    if (o_fir !== 3'b000) begin
      n_fail++;
      $display("FAIL ovr_tap3 got=%b exp=000", o_fir);
    end
    repeat (8) step();
    n_tests++;
    if ({o_ovr, o_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL ovr_still_set ovr,busy got=%b exp=10", {o_ovr, o_busy});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse(3'b001);
    repeat (TAPS + 1) step();
    n_tests++;
    if ({o_busy, o_ovr} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_last_busy busy,ovr got=%b exp=10", {o_busy, o_ovr});
    end
    pulse(3'b110);
    n_tests++;
    if ({o_csn, o_busy, o_ovr} !== 3'b101) begin
      n_fail++;
      $display("FAIL b2b_drop_at_fall csn,busy,ovr got=%b exp=101",
               {o_csn, o_busy, o_ovr});
    end
    step();
    n_tests++;
    if ({o_csn, o_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_stays_idle csn,busy got=%b exp=10", {o_csn, o_busy});
    end
  endtask

  task automatic test_update();
    do_reset();
    upd = 1'b1;
    pulse(3'b111);
    n_tests++;
    if ({o_csn, o_busy, o_ovr} !== 3'b100) begin
      n_fail++;
      $display("FAIL upd_block csn,busy,ovr got=%b exp=100", {o_csn, o_busy, o_ovr});
    end
    step();
    n_tests++;
    if ({o_csn, o_busy, o_ovr} !== 3'b100) begin
      n_fail++;
      $display("FAIL upd_block2 csn,busy,ovr got=%b exp=100", {o_csn, o_busy, o_ovr});
    end
    upd = 1'b0;
    pulse(3'b101);
    repeat (3) step();
    upd = 1'b1;
    repeat (8) step();
    n_tests++;
    if ({o_endly, o_insel, o_busy, o_coeff} !== {1'b1, 4'd10, 1'b1, 16'h0109}) begin
      n_fail++;
      $display("FAIL upd_run_done endly,insel,busy,coeff got=%h exp=%h",
               {o_endly, o_insel, o_busy, o_coeff}, {1'b1, 4'd10, 1'b1, 16'h0109});
    end
    step();
    n_tests++;
    if ({o_endly, o_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL upd_run_end endly,busy got=%b exp=00", {o_endly, o_busy});
    end
    upd = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [30:0] g;
    logic [DATA_W-1:0] ef;
    logic bad;
    do_reset();
    pulse(3'b100);
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    g = {o_csn, o_addr, o_coeff, o_fir, o_insel, o_endly, o_busy, o_ovr};
    n_tests++;
    if (g !== {1'b1, 30'b0}) begin
      n_fail++;
      $display("FAIL rstmid_vals got=%h exp=%h", g, {1'b1, 30'b0});
    end
    bad = 1'b0;
    for (int k = 0; k < TAPS + 2; k++) begin
      if (o_endly !== 1'b0 || o_csn !== 1'b1) bad = 1'b1;
      step();
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet got=%b exp=0", bad);
    end
    pulse(3'b110);
    step();
    step();
    for (int k = 2; k <= TAPS + 1; k++) begin
      ef = (k == 2) ? 3'b110 : 3'b000;
      n_tests++;
      if ({o_fir, o_insel} !== {ef, 4'(k - 1)}) begin
        n_fail++;
        $display("FAIL rstmid_tap%0d fir,insel got=%h exp=%h",
                 k - 1, {o_fir, o_insel}, {ef, 4'(k - 1)});
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_overrun();
    test_back_to_back();
    test_update();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
